// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_t;

  // Identity of the requester that wins an arbitration round.
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the memory port.
// The slave view is the arbiter itself (it serves both requesters and drives
// the memory side); the master view is everything around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch requester.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  // Load/store requester.
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  // Shared memory port.
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  // Hazard-unit stall hints.
  logic              if_stall;
  logic              d_stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, if_stall, d_stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, if_stall, d_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data
// accesses. Data has priority; a fetch that has watched MAX_WAIT data grants
// go by is forced through on the next round. One transaction in flight.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  import mem_port_arbiter_pkg::*;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  state_t            state, next_state;
  gnt_t              winner;
  logic              grant_if, grant_d, done_if, done_d;
  logic [CNT_W-1:0]  starve_cnt;

  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ready_q, d_ready_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  // Priority pick: data wins unless fetch is alone or has been starved.
  always_comb begin
    // NOTE: assigning a default before any condition keeps every path
    // driven, so no latch is inferred.
    winner = GNT_D;
    if (bus.if_req && (!bus.d_req || starve_cnt == CNT_MAX)) begin
      winner = GNT_IF;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments let every flop sample the pre-edge
    // values, independent of the order in which blocks are evaluated.
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state: grant from IDLE, return to IDLE when memory acknowledges.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          next_state = (winner == GNT_IF) ? ST_FETCH : ST_DATA;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (bus.mem_ack) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode: grant strobes in IDLE, completion strobes on mem_ack.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    done_if  = 1'b0;
    done_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        grant_if = (winner == GNT_IF);
        grant_d  = bus.d_req && (winner == GNT_D);
      end
      ST_FETCH: done_if = bus.mem_ack;
      ST_DATA:  done_d  = bus.mem_ack;
      default: ;
    endcase
  end

  // Memory-side request registers: loaded on a grant, held until mem_ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else if (grant_if) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= bus.if_addr;
      mem_wdata_q <= '0;
    end else if (grant_d) begin
      mem_req_q   <= 1'b1;
      mem_we_q    <= bus.d_we;
      mem_addr_q  <= bus.d_addr;
      mem_wdata_q <= bus.d_wdata;
    end else if (done_if || done_d) begin
      mem_req_q   <= 1'b0;
    end
  end

  // Response registers: one-cycle ready pulse, read data captured on ack.
  // Stores leave d_rdata untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_ready_q <= done_if;
      d_ready_q  <= done_d;
      if (done_if)              if_rdata_q <= bus.mem_rdata;
      if (done_d && !mem_we_q)  d_rdata_q  <= bus.mem_rdata;
    end
  end

  // Starvation counter: data grants seen by a waiting fetch, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && bus.if_req && starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_stall  = bus.if_req & ~if_ready_q;
  assign bus.d_stall   = bus.d_req  & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic, scored against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct { bit fetch; bit we; logic [31:0] addr; logic [31:0] wdata; int cyc; } grant_t;
  typedef struct { bit fetch; logic [31:0] data; int cyc; } rsp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; } dreq_t;

  grant_t      grant_q[$];
  rsp_t        rsp_q[$];
  gnt_t        grant_log[$];
  logic [31:0] if_todo[$];
  dreq_t       d_todo[$];
  logic [31:0] mem_arr[logic [31:0]];

  int cyc         = 0;
  int fixed_delay = -1;
  bit stray_en    = 1'b0;
  bit b2b         = 1'b0;
  int start_pct   = 100;

  initial forever @(posedge clk) cyc++;

  // Memory: acknowledges 1..3 cycles after seeing mem_req, stores into a
  // sparse array, and can throw stray acks while no request is up.
  initial begin
    bit in_txn;
    int waited;
    int delay;
    in_txn = 1'b0;
    waited = 0;
    delay  = 1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          waited = 0;
          delay  = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 3));
        end
        if (waited == delay) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            mem_arr[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = $urandom;
          end else begin
            bus.mem_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : $urandom;
          end
          in_txn = 1'b0;
        end else begin
          waited++;
        end
      end else begin
        in_txn = 1'b0;
        if (stray_en && $urandom_range(0, 7) == 0) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = $urandom;
        end
      end
    end
  end

  // Reference model: one access at a time; a request seen while the port is
  // free wins by the priority/starvation rule, occupies the port from the
  // next cycle until acknowledged, and is answered the cycle after the ack.
  initial begin
    bit          busy, rdy_if, rdy_d, fetch_wins;
    grant_t      cur;
    logic [31:0] m_if_rdata, m_d_rdata;
    int          waits;
    busy = 1'b0; rdy_if = 1'b0; rdy_d = 1'b0; waits = 0;
    m_if_rdata = '0; m_d_rdata = '0;
    cur = '{1'b0, 1'b0, 32'h0, 32'h0, 0};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0; rdy_if = 1'b0; rdy_d = 1'b0; waits = 0;
        m_if_rdata = '0; m_d_rdata = '0;
        grant_q.delete();
        rsp_q.delete();
      end else begin
        check("if_ready", bus.if_ready, rdy_if);
        check("d_ready", bus.d_ready, rdy_d);
        check("if_stall", bus.if_stall, bus.if_req & ~rdy_if);
        check("d_stall", bus.d_stall, bus.d_req & ~rdy_d);
        check("if_rdata", bus.if_rdata, m_if_rdata);
        check("d_rdata", bus.d_rdata, m_d_rdata);
        check("mem_req", bus.mem_req, busy);
        if (busy) begin
          check("mem_we_hold", bus.mem_we, cur.we);
          check("mem_addr_hold", bus.mem_addr, cur.addr);
          if (cur.we) check("mem_wdata_hold", bus.mem_wdata, cur.wdata);
        end
        rdy_if = 1'b0;
        rdy_d  = 1'b0;
        if (busy) begin
          if (bus.mem_ack) begin
            busy = 1'b0;
            if (cur.fetch) begin
              rdy_if = 1'b1;
              m_if_rdata = bus.mem_rdata;
              rsp_q.push_back('{1'b1, bus.mem_rdata, cyc + 1});
            end else begin
              rdy_d = 1'b1;
              if (!cur.we) m_d_rdata = bus.mem_rdata;
              rsp_q.push_back('{1'b0, m_d_rdata, cyc + 1});
            end
          end
        end else if (bus.if_req || bus.d_req) begin
          fetch_wins = bus.if_req && (!bus.d_req || waits >= MAX_WAIT);
          if (fetch_wins) begin
            cur = '{1'b1, 1'b0, bus.if_addr, 32'h0, cyc + 1};
            waits = 0;
          end else begin
            cur = '{1'b0, bus.d_we, bus.d_addr, bus.d_wdata, cyc + 1};
            if (bus.if_req && waits < MAX_WAIT) waits++;
          end
          grant_q.push_back(cur);
          busy = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT starts an access or
  // pulses a ready, and logs which requester actually got the port.
  initial begin
    bit     prev_req;
    grant_t g;
    rsp_t   r;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (bus.mem_req && !prev_req) begin
          grant_log.push_back(bus.mem_addr[31:20] == 12'h004 ? GNT_IF : GNT_D);
          if (grant_q.size() == 0) begin
            check("grant_q_depth", grant_q.size(), 1);
          end else begin
            g = grant_q.pop_front();
            check("grant_cycle", cyc, g.cyc);
            check("grant_addr", bus.mem_addr, g.addr);
            check("grant_we", bus.mem_we, g.we);
            if (g.we) check("grant_wdata", bus.mem_wdata, g.wdata);
          end
        end
        prev_req = bus.mem_req;
        if (bus.if_ready || bus.d_ready) begin
          if (rsp_q.size() == 0) begin
            check("rsp_q_depth", rsp_q.size(), 1);
          end else begin
            r = rsp_q.pop_front();
            check("rsp_cycle", cyc, r.cyc);
            check("rsp_is_fetch", bus.if_ready, r.fetch);
            check("rsp_data", r.fetch ? bus.if_rdata : bus.d_rdata, r.data);
          end
        end
      end
    end
  end

  task automatic present_if();
    bus.if_addr = if_todo.pop_front();
    bus.if_req  = 1'b1;
  endtask

  task automatic present_d();
    dreq_t t;
    t = d_todo.pop_front();
    bus.d_we    = t.we;
    bus.d_addr  = t.addr;
    bus.d_wdata = t.wdata;
    bus.d_req   = 1'b1;
  endtask

  // Requesters: hold req until ready, then chain or drop.
  task automatic drive();
    if (bus.if_req && bus.if_ready) begin
      bus.if_req = 1'b0;
      if (b2b && if_todo.size() > 0) present_if();
    end else if (!bus.if_req && if_todo.size() > 0 && $urandom_range(1, 100) <= start_pct) begin
      present_if();
    end
    if (bus.d_req && bus.d_ready) begin
      bus.d_req = 1'b0;
      if (b2b && d_todo.size() > 0) present_d();
    end else if (!bus.d_req && d_todo.size() > 0 && $urandom_range(1, 100) <= start_pct) begin
      present_d();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((if_todo.size() > 0 || d_todo.size() > 0 || bus.if_req || bus.d_req) && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_idle", {bus.if_req, bus.d_req, if_todo.size() != 0, d_todo.size() != 0}, 0);
    repeat (3) step();
  endtask

  initial begin
    int   n;
    int   pulses;
    gnt_t exp_pat[6];
    exp_pat = '{GNT_D, GNT_D, GNT_D, GNT_D, GNT_IF, GNT_D};

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset values.
    #1 rst_n = 1'b0;
    #2;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_if_ready", bus.if_ready, 0);
    check("rst_d_ready", bus.d_ready, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Fetch alone, memory acks two cycles after mem_req.
    fixed_delay = 2;
    step();
    bus.if_addr = 32'h0040_0000;
    bus.if_req  = 1'b1;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check("fetch_mem_req_cycle1", bus.mem_req, 1);
      if (bus.if_ready) break;
    end
    check("fetch_alone_latency", n, 4);
    bus.if_req = 1'b0;
    repeat (2) step();

    // Simultaneous fetch and load: data first.
    fixed_delay = -1;
    grant_log.delete();
    if_todo.push_back(32'h0040_0010);
    d_todo.push_back('{1'b0, 32'h1001_0000, 32'h0});
    drain(60);
    check("simul_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("simul_first", grant_log[0], GNT_D);
      check("simul_second", grant_log[1], GNT_IF);
    end

    // Starvation: data streams back to back while fetch waits.
    b2b = 1'b1;
    grant_log.delete();
    for (int i = 0; i < 6; i++) d_todo.push_back('{1'b0, 32'h1001_0100 + 32'(4 * i), 32'h0});
    if_todo.push_back(32'h0040_0100);
    if_todo.push_back(32'h0040_0104);
    drain(200);
    check("starve_grants", grant_log.size(), 8);
    if (grant_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) check($sformatf("starve_seq%0d", i), grant_log[i], exp_pat[i]);
    end

    // Store between two loads; the last load reads the stored word back.
    b2b = 1'b0;
    d_todo.push_back('{1'b0, 32'h1001_0008, 32'h0});
    d_todo.push_back('{1'b1, 32'h1001_0004, 32'hDEAD_BEEF});
    d_todo.push_back('{1'b0, 32'h1001_0004, 32'h0});
    drain(60);
    check("store_readback", bus.d_rdata, 32'hDEAD_BEEF);

    // Early drop: fetch request withdrawn once the access has started.
    step();
    bus.if_addr = 32'h0040_0020;
    bus.if_req  = 1'b1;
    n = 0;
    while (!bus.mem_req && n < 5) begin
      step();
      n++;
    end
    check("early_drop_started", bus.mem_req, 1);
    bus.if_req = 1'b0;
    pulses = 0;
    repeat (10) begin
      step();
      if (bus.if_ready) pulses++;
    end
    check("early_drop_pulses", pulses, 1);

    // Reset while a store is in flight, with a fetch also pending.
    fixed_delay = 3;
    d_todo.push_back('{1'b1, 32'h1001_000C, 32'h1234_5678});
    n = 0;
    while (!bus.mem_req && n < 5) begin
      step();
      n++;
    end
    check("rst_mid_started", bus.mem_req, 1);
    bus.if_addr = 32'h0040_0030;
    bus.if_req  = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_mem_we", bus.mem_we, 0);
    check("rst_mid_mem_addr", bus.mem_addr, 0);
    check("rst_mid_mem_wdata", bus.mem_wdata, 0);
    check("rst_mid_d_ready", bus.d_ready, 0);
    check("rst_mid_if_rdata", bus.if_rdata, 0);
    check("rst_mid_d_rdata", bus.d_rdata, 0);
    check("rst_mid_if_stall", bus.if_stall, 1);
    bus.d_req = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    n = 0;
    while (pulses == 0 && n < 12) begin
      step();
      n++;
      if (bus.if_ready) pulses++;
    end
    check("rst_mid_fetch_done", pulses, 1);
    repeat (2) step();

    // Randomized traffic with variable latency and stray acks.
    fixed_delay = -1;
    stray_en    = 1'b1;
    start_pct   = 60;
    repeat (600) begin
      if (if_todo.size() < 2 && $urandom_range(0, 3) == 0)
        if_todo.push_back(32'h0040_0000 | (32'($urandom_range(0, 255)) << 2));
      if (d_todo.size() < 2 && $urandom_range(0, 2) == 0)
        d_todo.push_back('{1'($urandom_range(0, 1)), 32'h1001_0000 | (32'($urandom_range(0, 15)) << 2), 32'($urandom)});
      b2b = 1'($urandom_range(0, 1));
      step();
    end
    start_pct = 100;
    drain(400);

    check("grant_q_empty", grant_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
